// File: rtl/eth_pkg.sv
// Constants, state encoding and field helpers shared by the UDP receive and
// transmit paths of the video Ethernet link.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hd5;
  localparam logic [47:0] BROADCAST_MAC = 48'hff_ff_ff_ff_ff_ff;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b000_0001,
    ST_PREAMBLE = 7'b000_0010,
    ST_ETH_HEAD = 7'b000_0100,
    ST_IP_HEAD  = 7'b000_1000,
    ST_UDP_HEAD = 7'b001_0000,
    ST_RX_DATA  = 7'b010_0000,
    ST_RX_END   = 7'b100_0000
  } rx_state_t;

  // Byte idx of a MAC address in wire order (idx 0 is the first byte sent).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ip[31:24];
      2'd1:    b = ip[23:16];
      2'd2:    b = ip[15:8];
      2'd3:    b = ip[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/video_trans_eth_udp_rx_word_pack.sv
// Packs payload bytes MSB-first into 32-bit words; a short final word is
// flushed left-aligned with its unused low bytes zero.
module eth_rx_word_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic        byte_last,
  input  logic [7:0]  byte_data,
  output logic        word_en,
  output logic [31:0] word_data
);

  logic [1:0]  lane_r;
  logic [31:0] acc_r;
  logic [31:0] acc_s;
  logic        word_en_r;
  logic [31:0] word_data_r;

  // Drop the incoming byte into its lane; lane 0 starts a fresh zeroed word.
  always_comb begin
    acc_s = acc_r;
    case (lane_r)
      2'd0:    acc_s = {byte_data, 24'h00_0000};
      2'd1:    acc_s[23:16] = byte_data;
      2'd2:    acc_s[15:8] = byte_data;
      2'd3:    acc_s[7:0] = byte_data;
      default: acc_s = acc_r;
    endcase
  end

  // Lane counter, assembler and registered word strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r      <= 2'd0;
      acc_r       <= 32'h0000_0000;
      word_en_r   <= 1'b0;
      word_data_r <= 32'h0000_0000;
    end else begin
      word_en_r <= 1'b0;
      if (clear) begin
        lane_r <= 2'd0;
      end else if (byte_valid) begin
        acc_r <= acc_s;
        if ((lane_r == 2'd3) || byte_last) begin
          word_en_r   <= 1'b1;
          word_data_r <= acc_s;
          lane_r      <= 2'd0;
        end else begin
          lane_r <= lane_r + 2'd1;
        end
      end
    end
  end

  assign word_en   = word_en_r;
  assign word_data = word_data_r;

endmodule

// File: rtl/video_trans_eth_udp_rx.sv
// GMII receive parser: validates preamble, Ethernet, IPv4 and UDP headers and
// delivers the UDP payload as big-endian 32-bit words.
module video_trans_eth_udp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num
);

  rx_state_t   state_r, next_state_s;
  logic [5:0]  hdr_cnt_r;
  logic [15:0] data_cnt_r;
  logic        dv_d_r;
  logic        uni_ok_r, bc_ok_r;
  logic [7:0]  type_hi_r;
  logic [3:0]  ihl_r;
  logic        ip_err_r;
  logic [7:0]  udp_hi_r;
  logic [15:0] udp_len_r;
  logic [15:0] byte_num_r;
  logic        done_r;
  logic        mac_match_s, bc_match_s, eth_ok_s, ip_byte_err_s, ip_last_s, data_last_s;

  // Per-byte header field checks against the byte currently on the bus.
  always_comb begin
    mac_match_s   = (gmii_rxd == mac_byte(BOARD_MAC, hdr_cnt_r[2:0]));
    bc_match_s    = (gmii_rxd == mac_byte(BROADCAST_MAC, hdr_cnt_r[2:0]));
    eth_ok_s      = (uni_ok_r | bc_ok_r) && ({type_hi_r, gmii_rxd} == ETH_TYPE_IPV4);
    ip_byte_err_s = 1'b0;
    if (hdr_cnt_r == 6'd9) begin
      ip_byte_err_s = (gmii_rxd != IP_PROTO_UDP);
    end else if ((hdr_cnt_r >= 6'd16) && (hdr_cnt_r <= 6'd19)) begin
      ip_byte_err_s = (gmii_rxd != ip_byte(BOARD_IP, hdr_cnt_r[1:0]));
    end else begin
      ip_byte_err_s = 1'b0;
    end
    ip_last_s   = (hdr_cnt_r != 6'd0) && (hdr_cnt_r == ({ihl_r, 2'b00} - 6'd1));
    data_last_s = (data_cnt_r == (byte_num_r - 16'd1));
  end

  // Next-state decode; any dv drop mid-frame aborts straight to idle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          // dv already high before this cycle (e.g. just out of reset) means a frame in flight.
          if ((gmii_rxd == PREAMBLE_BYTE) && !dv_d_r) next_state_s = ST_PREAMBLE;
          else                                        next_state_s = ST_RX_END;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_dv)                next_state_s = ST_IDLE;
        else if (hdr_cnt_r < 6'd6)      next_state_s = (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_RX_END;
        else if (gmii_rxd == SFD_BYTE)  next_state_s = ST_ETH_HEAD;
        else                            next_state_s = ST_RX_END;
      end
      ST_ETH_HEAD: begin
        if (!gmii_rx_dv)                next_state_s = ST_IDLE;
        else if (hdr_cnt_r == 6'd13)    next_state_s = eth_ok_s ? ST_IP_HEAD : ST_RX_END;
        else                            next_state_s = ST_ETH_HEAD;
      end
      ST_IP_HEAD: begin
        if (!gmii_rx_dv)                                    next_state_s = ST_IDLE;
        else if ((hdr_cnt_r == 6'd0) && (gmii_rxd[3:0] < 4'd5)) next_state_s = ST_RX_END;
        else if (ip_last_s)  next_state_s = (ip_err_r | ip_byte_err_s) ? ST_RX_END : ST_UDP_HEAD;
        else                                                next_state_s = ST_IP_HEAD;
      end
      ST_UDP_HEAD: begin
        if (!gmii_rx_dv)                next_state_s = ST_IDLE;
        else if (hdr_cnt_r == 6'd7)     next_state_s = (udp_len_r >= 16'd9) ? ST_RX_DATA : ST_RX_END;
        else                            next_state_s = ST_UDP_HEAD;
      end
      ST_RX_DATA: begin
        if (!gmii_rx_dv)                next_state_s = ST_IDLE;
        else if (data_last_s)           next_state_s = ST_RX_END;
        else                            next_state_s = ST_RX_DATA;
      end
      ST_RX_END: begin
        if (!gmii_rx_dv)                next_state_s = ST_IDLE;
        else                            next_state_s = ST_RX_END;
      end
      default:                          next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Byte counters, latched header fields and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt_r  <= 6'd0;
      data_cnt_r <= 16'd0;
      dv_d_r     <= 1'b1;
      uni_ok_r   <= 1'b0;
      bc_ok_r    <= 1'b0;
      type_hi_r  <= 8'd0;
      ihl_r      <= 4'd0;
      ip_err_r   <= 1'b0;
      udp_hi_r   <= 8'd0;
      udp_len_r  <= 16'd0;
      byte_num_r <= 16'd0;
      done_r     <= 1'b0;
    end else begin
      dv_d_r <= gmii_rx_dv;
      done_r <= 1'b0;
      if (next_state_s != state_r) hdr_cnt_r <= 6'd0;
      else if (gmii_rx_dv)         hdr_cnt_r <= hdr_cnt_r + 6'd1;
      if ((state_r == ST_RX_DATA) && gmii_rx_dv) data_cnt_r <= data_cnt_r + 16'd1;
      else                                        data_cnt_r <= 16'd0;
      case (state_r)
        ST_PREAMBLE: begin
          uni_ok_r <= 1'b1;
          bc_ok_r  <= 1'b1;
        end
        ST_ETH_HEAD: begin
          if (hdr_cnt_r < 6'd6) begin
            uni_ok_r <= uni_ok_r & mac_match_s;
            bc_ok_r  <= bc_ok_r & bc_match_s;
          end
          if (hdr_cnt_r == 6'd12) type_hi_r <= gmii_rxd;
        end
        ST_IP_HEAD: begin
          if (hdr_cnt_r == 6'd0) begin
            ihl_r    <= gmii_rxd[3:0];
            ip_err_r <= (gmii_rxd[7:4] != 4'd4);
          end else begin
            ip_err_r <= ip_err_r | ip_byte_err_s;
          end
        end
        ST_UDP_HEAD: begin
          if (hdr_cnt_r == 6'd4) udp_hi_r <= gmii_rxd;
          if (hdr_cnt_r == 6'd5) udp_len_r <= {udp_hi_r, gmii_rxd};
          if (next_state_s == ST_RX_DATA) byte_num_r <= udp_len_r - 16'd8;
        end
        ST_RX_DATA: done_r <= gmii_rx_dv & data_last_s;
        default: done_r <= 1'b0;
      endcase
    end
  end

  eth_rx_word_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_r != ST_RX_DATA),
    .byte_valid ((state_r == ST_RX_DATA) && gmii_rx_dv),
    .byte_last  (data_last_s),
    .byte_data  (gmii_rxd),
    .word_en    (rec_en),
    .word_data  (rec_data)
  );

  assign rec_pkt_done = done_r;
  assign rec_byte_num = byte_num_r;

endmodule

// File: tb/tb_video_trans_eth_udp_rx.sv
// Randomized frame-level bench for video_trans_eth_udp_rx with a byte-array
// reference parser.
module tb_video_trans_eth_udp_rx;
  import eth_pkg::*;

  localparam logic [47:0] MY_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] MY_IP  = {8'd192, 8'd168, 8'd1, 8'd123};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  pay_q[$];
  logic [31:0] exp_words[$];
  logic [31:0] got_words[$];
  int          exp_done;
  int          got_done;
  int          bad_align;
  logic [15:0] exp_num = 16'd0;

  video_trans_eth_udp_rx dut (
    .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
    .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (rec_en) got_words.push_back(rec_data);
    if (rec_pkt_done) begin
      got_done++;
      if (!rec_en) bad_align++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype, input int ihl,
                             input logic [31:0] dip, input logic [7:0] proto, input int ulen_ovr);
    int ulen;
    ulen = (ulen_ovr < 0) ? pay_q.size() + 8 : ulen_ovr;
    frame_q.delete();
    repeat (7) frame_q.push_back(8'h55);
    frame_q.push_back(8'hd5);
    for (int i = 0; i < 6; i++) frame_q.push_back(dmac[47-8*i -: 8]);
    repeat (6) frame_q.push_back(8'($urandom));
    frame_q.push_back(etype[15:8]);
    frame_q.push_back(etype[7:0]);
    frame_q.push_back({4'd4, 4'(ihl)});
    frame_q.push_back(8'($urandom));
    frame_q.push_back(8'((ihl * 4 + ulen) >> 8));
    frame_q.push_back(8'(ihl * 4 + ulen));
    repeat (4) frame_q.push_back(8'($urandom));
    frame_q.push_back(8'd64);
    frame_q.push_back(proto);
    repeat (6) frame_q.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) frame_q.push_back(dip[31-8*i -: 8]);
    for (int i = 20; i < ihl * 4; i++) frame_q.push_back(8'($urandom));
    repeat (4) frame_q.push_back(8'($urandom));
    frame_q.push_back(8'(ulen >> 8));
    frame_q.push_back(8'(ulen));
    repeat (2) frame_q.push_back(8'($urandom));
    foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
    while (frame_q.size() < 68) frame_q.push_back(8'($urandom));
    repeat (4) frame_q.push_back(8'($urandom));
  endtask

  // Reference parser over the frame bytes; sent = number of bytes delivered with dv high.
  function automatic void model_frame(input int sent);
    int ip, udp, pl, ihl, ulen, dlen, avail;
    logic ok;
    logic [47:0] dmac;
    logic [31:0] w;
    exp_words.delete();
    exp_done = 0;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) if (frame_q[i] != 8'h55) ok = 1'b0;
    if (frame_q[7] != 8'hd5) ok = 1'b0;
    dmac = 48'd0;
    for (int i = 0; i < 6; i++) dmac = {dmac[39:0], frame_q[8+i]};
    if (dmac != MY_MAC && dmac != 48'hffff_ffff_ffff) ok = 1'b0;
    if ({frame_q[20], frame_q[21]} != 16'h0800) ok = 1'b0;
    ip = 22;
    ihl = int'(frame_q[ip][3:0]);
    if (frame_q[ip][7:4] != 4'd4 || ihl < 5) ok = 1'b0;
    if (ok && frame_q[ip+9] != 8'd17) ok = 1'b0;
    if (ok && {frame_q[ip+16], frame_q[ip+17], frame_q[ip+18], frame_q[ip+19]} != MY_IP) ok = 1'b0;
    if (!ok) return;
    udp = ip + ihl * 4;
    ulen = int'({frame_q[udp+4], frame_q[udp+5]});
    if (ulen < 9 || sent < udp + 8) return;
    dlen = ulen - 8;
    exp_num = 16'(dlen);
    pl = udp + 8;
    avail = sent - pl;
    if (avail > dlen) avail = dlen;
    for (int k = 0; k + 4 <= avail; k += 4)
      exp_words.push_back({frame_q[pl+k], frame_q[pl+k+1], frame_q[pl+k+2], frame_q[pl+k+3]});
    if (sent - pl >= dlen) begin
      exp_done = 1;
      if (dlen % 4 != 0) begin
        w = 32'd0;
        for (int j = 0; j < dlen % 4; j++) w[31-8*j -: 8] = frame_q[pl + dlen - dlen % 4 + j];
        exp_words.push_back(w);
      end
    end
  endfunction

  task automatic clear_got();
    got_words.delete();
    got_done = 0;
    bad_align = 0;
  endtask

  task automatic send_bytes(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd = frame_q[i];
    end
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    repeat (14) @(posedge clk);
  endtask

  task automatic rand_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (rec_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rec_en: got %0b want 0", rec_en); end
    tests_run++; if (rec_data !== 32'd0) begin tests_failed++; $display("FAIL reset_rec_data: got %h want 0", rec_data); end
    tests_run++; if (rec_pkt_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0b want 0", rec_pkt_done); end
    tests_run++; if (rec_byte_num !== 16'd0) begin tests_failed++; $display("FAIL reset_byte_num: got %0d want 0", rec_byte_num); end
    tests_run++; if (dut.state_r !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %b want idle", dut.state_r); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_unicast();
    pay_q.delete();
    for (int i = 1; i <= 8; i++) pay_q.push_back(8'(i));
    build_frame(MY_MAC, 16'h0800, 5, MY_IP, 8'd17, -1);
    model_frame(frame_q.size());
    clear_got(); send_bytes(0, frame_q.size()); end_frame();
    tests_run++; if (got_words.size() != exp_words.size()) begin tests_failed++; $display("FAIL unicast_count: got %0d want %0d", got_words.size(), exp_words.size()); end
    for (int k = 0; k < exp_words.size() && k < got_words.size(); k++) begin
      tests_run++; if (got_words[k] !== exp_words[k]) begin tests_failed++; $display("FAIL unicast_word%0d: got %h want %h", k, got_words[k], exp_words[k]); end
    end
    tests_run++; if (got_done !== exp_done || bad_align !== 0) begin tests_failed++; $display("FAIL unicast_done: got %0d (misaligned %0d) want %0d", got_done, bad_align, exp_done); end
    tests_run++; if (rec_byte_num !== exp_num) begin tests_failed++; $display("FAIL unicast_byte_num: got %0d want %0d", rec_byte_num, exp_num); end
  endtask

  task automatic test_broadcast();
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    build_frame(48'hffff_ffff_ffff, 16'h0800, 5, MY_IP, 8'd17, -1);
    model_frame(frame_q.size());
    clear_got(); send_bytes(0, frame_q.size()); end_frame();
    tests_run++; if (got_words.size() != exp_words.size()) begin tests_failed++; $display("FAIL bcast_count: got %0d want %0d", got_words.size(), exp_words.size()); end
    for (int k = 0; k < exp_words.size() && k < got_words.size(); k++) begin
      tests_run++; if (got_words[k] !== exp_words[k]) begin tests_failed++; $display("FAIL bcast_word%0d: got %h want %h", k, got_words[k], exp_words[k]); end
    end
    tests_run++; if (got_done !== exp_done || bad_align !== 0) begin tests_failed++; $display("FAIL bcast_done: got %0d (misaligned %0d) want %0d", got_done, bad_align, exp_done); end
    tests_run++; if (rec_byte_num !== exp_num) begin tests_failed++; $display("FAIL bcast_byte_num: got %0d want %0d", rec_byte_num, exp_num); end
  endtask

  // Alternates a rejected frame (bad IP, bad MAC, ARP type, bad protocol) with a good one.
  task automatic test_rejects();
    for (int f = 0; f < 8; f++) begin
      rand_payload($urandom_range(1, 24));
      case (f)
        0: build_frame(MY_MAC, 16'h0800, 5, {8'd192, 8'd168, 8'd1, 8'd200}, 8'd17, -1);
        2: build_frame(48'h00_11_22_33_44_56, 16'h0800, 5, MY_IP, 8'd17, -1);
        4: build_frame(MY_MAC, 16'h0806, 5, MY_IP, 8'd17, -1);
        6: build_frame(MY_MAC, 16'h0800, 5, MY_IP, 8'd6, -1);
        default: build_frame(MY_MAC, 16'h0800, 5, MY_IP, 8'd17, -1);
      endcase
      model_frame(frame_q.size());
      clear_got(); send_bytes(0, frame_q.size()); end_frame();
      tests_run++; if (got_words.size() != exp_words.size()) begin tests_failed++; $display("FAIL reject%0d_count: got %0d want %0d", f, got_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < got_words.size(); k++) begin
        tests_run++; if (got_words[k] !== exp_words[k]) begin tests_failed++; $display("FAIL reject%0d_word%0d: got %h want %h", f, k, got_words[k], exp_words[k]); end
      end
      tests_run++; if (got_done !== exp_done || bad_align !== 0) begin tests_failed++; $display("FAIL reject%0d_done: got %0d (misaligned %0d) want %0d", f, got_done, bad_align, exp_done); end
      tests_run++; if (rec_byte_num !== exp_num) begin tests_failed++; $display("FAIL reject%0d_byte_num: got %0d want %0d", f, rec_byte_num, exp_num); end
    end
  endtask

  task automatic test_ip_options();
    rand_payload(4);
    build_frame(MY_MAC, 16'h0800, 6, MY_IP, 8'd17, -1);
    model_frame(frame_q.size());
    clear_got(); send_bytes(0, frame_q.size()); end_frame();
    tests_run++; if (got_words.size() != exp_words.size()) begin tests_failed++; $display("FAIL ihl6_count: got %0d want %0d", got_words.size(), exp_words.size()); end
    for (int k = 0; k < exp_words.size() && k < got_words.size(); k++) begin
      tests_run++; if (got_words[k] !== exp_words[k]) begin tests_failed++; $display("FAIL ihl6_word%0d: got %h want %h", k, got_words[k], exp_words[k]); end
    end
    tests_run++; if (got_done !== exp_done || bad_align !== 0) begin tests_failed++; $display("FAIL ihl6_done: got %0d (misaligned %0d) want %0d", got_done, bad_align, exp_done); end
    tests_run++; if (rec_byte_num !== exp_num) begin tests_failed++; $display("FAIL ihl6_byte_num: got %0d want %0d", rec_byte_num, exp_num); end
  endtask

  task automatic test_short_udp();
    pay_q.delete();
    build_frame(MY_MAC, 16'h0800, 5, MY_IP, 8'd17, 8);
    model_frame(frame_q.size());
    clear_got(); send_bytes(0, frame_q.size()); end_frame();
    tests_run++; if (got_words.size() != 0 || got_done != 0) begin tests_failed++; $display("FAIL short_udp: got %0d words %0d done want none", got_words.size(), got_done); end
    tests_run++; if (rec_byte_num !== exp_num) begin tests_failed++; $display("FAIL short_udp_byte_num: got %0d want %0d", rec_byte_num, exp_num); end
  endtask

  task automatic test_dv_drop();
    rand_payload(10);
    build_frame(MY_MAC, 16'h0800, 5, MY_IP, 8'd17, -1);
    model_frame(56);
    clear_got(); send_bytes(0, 56);
    @(posedge clk); #1 gmii_rx_dv = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (dut.state_r !== ST_IDLE) begin tests_failed++; $display("FAIL dv_drop_state: got %b want idle", dut.state_r); end
    repeat (14) @(posedge clk);
    tests_run++; if (got_words.size() != exp_words.size()) begin tests_failed++; $display("FAIL dv_drop_count: got %0d want %0d", got_words.size(), exp_words.size()); end
    for (int k = 0; k < exp_words.size() && k < got_words.size(); k++) begin
      tests_run++; if (got_words[k] !== exp_words[k]) begin tests_failed++; $display("FAIL dv_drop_word%0d: got %h want %h", k, got_words[k], exp_words[k]); end
    end
    tests_run++; if (got_done != exp_done) begin tests_failed++; $display("FAIL dv_drop_done: got %0d want %0d", got_done, exp_done); end
  endtask

  task automatic test_reset_mid_frame();
    rand_payload(10);
    build_frame(MY_MAC, 16'h0800, 5, MY_IP, 8'd17, -1);
    model_frame(56);
    clear_got(); send_bytes(0, 56);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_num = 16'd0;
    #1;
    tests_run++; if (rec_byte_num !== 16'd0 || rec_data !== 32'd0 || rec_en !== 1'b0 || rec_pkt_done !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got num %0d data %h en %0b done %0b want all 0", rec_byte_num, rec_data, rec_en, rec_pkt_done);
    end
    send_bytes(56, 58);
    @(posedge clk); #1 rst_n = 1'b1;
    send_bytes(58, frame_q.size()); end_frame();
    tests_run++; if (got_words.size() != exp_words.size() || got_done != 0) begin tests_failed++; $display("FAIL mid_reset_frame: got %0d words %0d done want %0d words 0 done", got_words.size(), got_done, exp_words.size()); end
    tests_run++; if (rec_byte_num !== exp_num) begin tests_failed++; $display("FAIL mid_reset_byte_num: got %0d want %0d", rec_byte_num, exp_num); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] mac;
    for (int f = 0; f < 10; f++) begin
      rand_payload($urandom_range(1, 40));
      mac = ($urandom_range(0, 3) == 0) ? 48'hffff_ffff_ffff : MY_MAC;
      if ($urandom_range(0, 4) == 0) mac = {16'h0211, 32'($urandom)};
      build_frame(mac, ($urandom_range(0, 5) == 0) ? 16'h86dd : 16'h0800, $urandom_range(5, 7),
                  ($urandom_range(0, 5) == 0) ? {24'hc0a801, 8'($urandom_range(0, 100))} : MY_IP,
                  ($urandom_range(0, 5) == 0) ? 8'd6 : 8'd17, -1);
      model_frame(frame_q.size());
      clear_got(); send_bytes(0, frame_q.size()); end_frame();
      tests_run++; if (got_words.size() != exp_words.size()) begin tests_failed++; $display("FAIL b2b%0d_count: got %0d want %0d", f, got_words.size(), exp_words.size()); end
      for (int k = 0; k < exp_words.size() && k < got_words.size(); k++) begin
        tests_run++; if (got_words[k] !== exp_words[k]) begin tests_failed++; $display("FAIL b2b%0d_word%0d: got %h want %h", f, k, got_words[k], exp_words[k]); end
      end
      tests_run++; if (got_done !== exp_done || bad_align !== 0) begin tests_failed++; $display("FAIL b2b%0d_done: got %0d (misaligned %0d) want %0d", f, got_done, bad_align, exp_done); end
      tests_run++; if (rec_byte_num !== exp_num) begin tests_failed++; $display("FAIL b2b%0d_byte_num: got %0d want %0d", f, rec_byte_num, exp_num); end
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_rejects();
    test_ip_options();
    test_short_udp();
    test_dv_drop();
    test_reset_mid_frame();
    test_unicast();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
